mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 74 +++++++
 rtl/mem_arbiter_rr.sv | 44 ++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the CPU-space memory map for the multi-master memory arbiter.
package mem_arb_pkg;

    typedef enum logic [3:0] {
        SL_ROM,
        SL_WRAM,
        SL_OAM,
        SL_VRAM,
        SL_TIMER,
        SL_INTS,
        SL_HRAM,
        SL_DMA,
        SL_APU
    } slave_e;

    localparam int unsigned NUM_SLAVES    = 9;
    localparam int unsigned MAP_AW        = 16;
    localparam logic [7:0]  OPEN_BUS      = 8'hFF;
    localparam logic [3:0]  DEF_PRIO_MASK = 4'b1100;

    typedef struct packed {
        logic              mapped;
        slave_e            slv;
        logic [MAP_AW-1:0] off;
    } decode_t;

    function automatic decode_t mmap_decode(input logic [MAP_AW-1:0] addr);
        decode_t d;
        d.mapped = 1'b1;
        d.slv    = SL_ROM;
        d.off    = '0;
        if (addr <= 16'h7FFF) begin
            d.slv = SL_ROM;
            d.off = addr;
        end else if (addr <= 16'h9FFF) begin
            d.slv = SL_VRAM;
            d.off = addr - 16'h8000;
        end else if (addr <= 16'hBFFF) begin
            d.mapped = 1'b0;
        end else if (addr <= 16'hDFFF) begin
            d.slv = SL_WRAM;
            d.off = addr - 16'hC000;
        end else if (addr <= 16'hFDFF) begin
            // Echo region aliases work RAM.
            d.slv = SL_WRAM;
            d.off = addr - 16'hE000;
        end else if (addr <= 16'hFE9F) begin
            d.slv = SL_OAM;
            d.off = addr - 16'hFE00;
        end else if (addr >= 16'hFF04 && addr <= 16'hFF07) begin
            d.slv = SL_TIMER;
            d.off = addr - 16'hFF04;
        end else if (addr == 16'hFF0F) begin
            d.slv = SL_INTS;
            d.off = 16'h0000;
        end else if (addr >= 16'hFF10 && addr <= 16'hFF3F) begin
            d.slv = SL_APU;
            d.off = addr - 16'hFF10;
        end else if (addr == 16'hFF46) begin
            d.slv = SL_DMA;
            d.off = 16'h0000;
        end else if (addr >= 16'hFF80 && addr <= 16'hFFFE) begin
            d.slv = SL_HRAM;
            d.off = addr - 16'hFF80;
        end else if (addr == 16'hFFFF) begin
            d.slv = SL_INTS;
            d.off = 16'h0001;
        end else begin
            d.mapped = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Per-slave arbiter: fixed priority for masked masters, round-robin after ptr_i for the rest.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  prio_i,
    input  logic [N-1:0]  excl_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] pri_req;
    logic [N-1:0] rr_req;
    logic         found;

    assign pri_req = req_i & ~excl_i & prio_i;
    assign rr_req  = req_i & ~excl_i & ~prio_i;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && pri_req[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Two passes emulate the wrap: first indices above the pointer, then the rest.
        for (int i = 0; i < N; i++) begin
            if (!found && rr_req[i] && (i > int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && rr_req[i] && (i <= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-master to multi-slave memory arbiter with 0-cycle grants, bounded locking and
// 1-cycle read return.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       N_M       = 4,
    parameter int unsigned       N_S       = NUM_SLAVES,
    parameter int unsigned       AW        = 16,
    parameter int unsigned       DW        = 8,
    parameter logic [N_M-1:0]    PRIO_MASK = N_M'(DEF_PRIO_MASK),
    parameter int unsigned       MAX_LOCK  = 160
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_M-1:0]      m_req,
    input  logic [N_M-1:0]      m_we,
    input  logic [N_M-1:0]      m_lock,
    input  logic [N_M*AW-1:0]   m_addr,
    input  logic [N_M*DW-1:0]   m_wdata,
    output logic [N_M-1:0]      m_gnt,
    output logic [N_M-1:0]      m_rvalid,
    output logic [N_M*DW-1:0]   m_rdata,
    output logic [N_S-1:0]      s_en,
    output logic [N_S-1:0]      s_we,
    output logic [N_S*AW-1:0]   s_addr,
    output logic [N_S*DW-1:0]   s_wdata,
    input  logic [N_S*DW-1:0]   s_rdata
);

    localparam int unsigned PW  = (N_M > 1) ? $clog2(N_M) : 1;
    localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

    decode_t        dec      [N_M];
    logic [N_M-1:0] slv_req  [N_S];
    logic [N_M-1:0] arb_gnt  [N_S];
    logic [N_M-1:0] slv_gnt  [N_S];
    logic [PW-1:0]  win      [N_S];
    logic [N_S-1:0] hold;

    logic [PW-1:0]  rr_ptr_q [N_S];
    logic [PW-1:0]  rr_ptr_d [N_S];
    logic [N_S-1:0] lock_q, lock_d;
    logic [PW-1:0]  owner_q  [N_S];
    logic [PW-1:0]  owner_d  [N_S];
    logic [LCW-1:0] cnt_q    [N_S];
    logic [LCW-1:0] cnt_d    [N_S];
    logic [LCW-1:0] cnt_nxt;
    logic [N_M-1:0] excl_q   [N_S];
    logic [N_M-1:0] excl_d   [N_S];

    logic [N_M-1:0] rd_q, rd_d;
    logic [N_M-1:0] rmap_q, rmap_d;
    slave_e         rsel_q   [N_M];
    slave_e         rsel_d   [N_M];

    always_comb begin
        for (int m = 0; m < N_M; m++) begin
            dec[m] = mmap_decode(MAP_AW'(m_addr[m*AW +: AW]));
        end
        for (int s = 0; s < N_S; s++) begin
            for (int m = 0; m < N_M; m++) begin
                slv_req[s][m] = m_req[m] & dec[m].mapped & (int'(dec[m].slv) == s);
            end
        end
    end

    for (genvar gs = 0; gs < N_S; gs++) begin : g_arb
        rr_arbiter #(
            .N  (N_M),
            .PW (PW)
        ) u_arb (
            .req_i  (slv_req[gs]),
            .prio_i (PRIO_MASK),
            .excl_i (excl_q[gs]),
            .ptr_i  (rr_ptr_q[gs]),
            .gnt_o  (arb_gnt[gs])
        );
    end

    // A held lock overrides the arbiter while the owner keeps targeting the same slave.
    always_comb begin
        m_gnt   = '0;
        s_en    = '0;
        s_we    = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int s = 0; s < N_S; s++) begin
            hold[s]    = lock_q[s] && slv_req[s][owner_q[s]];
            slv_gnt[s] = hold[s] ? (N_M'(1) << owner_q[s]) : arb_gnt[s];
            if (rst) begin
                slv_gnt[s] = '0;
            end
            win[s] = '0;
            for (int m = 0; m < N_M; m++) begin
                if (slv_gnt[s][m]) begin
                    win[s]                = PW'(m);
                    m_gnt[m]              = 1'b1;
                    s_en[s]               = 1'b1;
                    s_we[s]               = m_we[m];
                    s_addr[s*AW +: AW]    = AW'(dec[m].off);
                    s_wdata[s*DW +: DW]   = m_wdata[m*DW +: DW];
                end
            end
        end
        for (int m = 0; m < N_M; m++) begin
            if (!rst && m_req[m] && !dec[m].mapped) begin
                m_gnt[m] = 1'b1;
            end
        end
    end

    always_comb begin
        lock_d  = '0;
        cnt_nxt = '0;
        for (int s = 0; s < N_S; s++) begin
            rr_ptr_d[s] = rr_ptr_q[s];
            owner_d[s]  = owner_q[s];
            cnt_d[s]    = '0;
            excl_d[s]   = '0;
            if (s_en[s]) begin
                if (!PRIO_MASK[win[s]]) begin
                    rr_ptr_d[s] = win[s];
                end
                if (m_lock[win[s]]) begin
                    if (lock_q[s] && (owner_q[s] == win[s])) begin
                        cnt_nxt = (cnt_q[s] == LCW'(MAX_LOCK)) ? cnt_q[s] : cnt_q[s] + LCW'(1);
                    end else begin
                        cnt_nxt = LCW'(1);
                    end
                    if (cnt_nxt >= LCW'(MAX_LOCK)) begin
                        excl_d[s][win[s]] = 1'b1;
                    end else begin
                        lock_d[s]  = 1'b1;
                        owner_d[s] = win[s];
                        cnt_d[s]   = cnt_nxt;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_d = m_gnt & ~m_we;
        for (int m = 0; m < N_M; m++) begin
            rsel_d[m] = dec[m].slv;
            rmap_d[m] = dec[m].mapped;
        end
    end

    always_comb begin
        m_rvalid = rst ? '0 : rd_q;
        for (int m = 0; m < N_M; m++) begin
            m_rdata[m*DW +: DW] = DW'(OPEN_BUS);
            if (!rst && rd_q[m] && rmap_q[m]) begin
                for (int s = 0; s < N_S; s++) begin
                    if (int'(rsel_q[m]) == s) begin
                        m_rdata[m*DW +: DW] = s_rdata[s*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
            rd_q   <= '0;
            rmap_q <= '0;
            for (int s = 0; s < N_S; s++) begin
                rr_ptr_q[s] <= PW'(N_M - 1);
                owner_q[s]  <= '0;
                cnt_q[s]    <= '0;
                excl_q[s]   <= '0;
            end
            for (int m = 0; m < N_M; m++) begin
                rsel_q[m] <= SL_ROM;
            end
        end else begin
            lock_q <= lock_d;
            rd_q   <= rd_d;
            rmap_q <= rmap_d;
            for (int s = 0; s < N_S; s++) begin
                rr_ptr_q[s] <= rr_ptr_d[s];
                owner_q[s]  <= owner_d[s];
                cnt_q[s]    <= cnt_d[s];
                excl_q[s]   <= excl_d[s];
            end
            for (int m = 0; m < N_M; m++) begin
                rsel_q[m] <= rsel_d[m];
            end
        end
    end

endmodule
